// File: rtl/file_reg.sv
`default_nettype none
// ============================================================================
//  Module      : file_reg
//  Description : Data-memory (file register) stage: direct/indirect operand
//                read, write-back of alu results, STATUS flags and FSR.
//  Revision    : 1.0 - initial release
// ============================================================================
module file_reg #(
    parameter int DEPTH       = 128,
    parameter int ADDR_W      = 7,
    parameter int INDF_ADDR   = 0,
    parameter int STATUS_ADDR = 3,
    parameter int FSR_ADDR    = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic [7:0]        ans,
    input  logic              d,
    input  logic              wr_en,
    input  logic [2:0]        flag_we,
    input  logic [2:0]        flags_in,
    output logic [7:0]        f,
    output logic              carry,
    output logic [7:0]        status
);

    localparam logic [ADDR_W-1:0] c_INDF   = ADDR_W'(INDF_ADDR);
    localparam logic [ADDR_W-1:0] c_STATUS = ADDR_W'(STATUS_ADDR);
    localparam logic [ADDR_W-1:0] c_FSR    = ADDR_W'(FSR_ADDR);

    // STATUS and FSR live in the array itself so reads of them need no mux.
    logic [7:0]        r_mem [DEPTH];

    logic [ADDR_W-1:0] w_fsr_ptr;
    logic [ADDR_W-1:0] w_ea;
    logic              w_null;
    logic              w_we;
    logic [7:0]        w_status_base;
    logic [7:0]        w_status_next;

    assign w_fsr_ptr = r_mem[c_FSR][ADDR_W-1:0];
    assign w_ea      = (address == c_INDF) ? w_fsr_ptr : address;
    // An indirect access that lands back on INDF has no backing storage.
    assign w_null    = (w_ea == c_INDF);
    assign w_we      = wr_en & d & ~w_null;

    // Flag enables win per bit over a concurrent direct write to STATUS.
    assign w_status_base = (w_we && (w_ea == c_STATUS)) ? ans : r_mem[c_STATUS];
    assign w_status_next = {w_status_base[7:3],
                            (flag_we & flags_in) | (~flag_we & w_status_base[2:0])};

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 8'h00;
            end
        end else begin
            if (w_we) begin
                r_mem[w_ea] <= ans;
            end
            r_mem[c_STATUS] <= w_status_next;
        end
    end

    assign f      = w_null ? 8'h00 : r_mem[w_ea];
    assign status = r_mem[c_STATUS];
    assign carry  = r_mem[c_STATUS][0];

endmodule
`default_nettype wire

// File: tb/tb_file_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_file_reg
//  Description : Scoreboard bench for file_reg with directed and random traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_file_reg;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] address;
    logic [7:0] ans;
    logic       d;
    logic       wr_en;
    logic [2:0] flag_we;
    logic [2:0] flags_in;
    logic [7:0] f;
    logic       carry;
    logic [7:0] status;

    always #5 clk = ~clk;

    file_reg dut (
        .clk      (clk),
        .reset    (reset),
        .address  (address),
        .ans      (ans),
        .d        (d),
        .wr_en    (wr_en),
        .flag_we  (flag_we),
        .flags_in (flags_in),
        .f        (f),
        .carry    (carry),
        .status   (status)
    );

    typedef struct {
        logic [7:0] f;
        logic [7:0] st;
        logic       c;
        int         cyc;
    } exp_t;

    exp_t       sb[$];
    exp_t       me;
    logic [7:0] m [128];
    bit         model_ok = 1'b0;
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;

    // Reference: a plain byte array; location 0 is the INDF alias, 3 STATUS, 4 FSR.
    function automatic int target(input logic [6:0] a);
        return (a == 7'd0) ? int'(m[4][6:0]) : int'(a);
    endfunction

    function automatic logic [7:0] model_read(input logic [6:0] a);
        int t;
        t = target(a);
        return (t == 0) ? 8'h00 : m[t];
    endfunction

    task automatic drive(input logic rs, input logic [6:0] a, input logic [7:0] x,
                         input logic dd, input logic we,
                         input logic [2:0] fw, input logic [2:0] fi);
        exp_t e;
        int   t;
        reset = rs; address = a; ans = x; d = dd; wr_en = we;
        flag_we = fw; flags_in = fi;
        if (model_ok) begin
            e.f = model_read(a); e.st = m[3]; e.c = m[3][0]; e.cyc = cyc;
            sb.push_back(e);
        end
        t = target(a);
        @(posedge clk);
        if (rs) begin
            for (int i = 0; i < 128; i++) m[i] = 8'h00;
            model_ok = 1'b1;
        end else if (model_ok) begin
            if (we && dd && t != 0) m[t] = x;
            for (int i = 0; i < 3; i++) if (fw[i]) m[3][i] = fi[i];
        end
        #1;
        cyc++;
    endtask

    task automatic rd(input logic [6:0] a);
        drive(1'b0, a, 8'hA5, 1'b0, 1'b1, 3'b000, 3'b111);
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            me = sb.pop_front();
            checks += 3;
            if (f !== me.f) begin
                errors++;
                $display("FAIL f cyc=%0d addr=%h got=%h exp=%h", me.cyc, address, f, me.f);
            end
            if (status !== me.st) begin
                errors++;
                $display("FAIL status cyc=%0d got=%h exp=%h", me.cyc, status, me.st);
            end
            if (carry !== me.c) begin
                errors++;
                $display("FAIL carry cyc=%0d got=%b exp=%b", me.cyc, carry, me.c);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [6:0] a;
        logic [7:0] x;
        int         r;
        drive(1'b1, 7'h20, 8'h5A, 1'b1, 1'b1, 3'b111, 3'b111);
        drive(1'b1, 7'h20, 8'h5A, 1'b1, 1'b1, 3'b111, 3'b111);
        for (int i = 0; i < 128; i++) rd(7'(i));
        // Basic write, then d=0 must leave the location alone.
        drive(1'b0, 7'h20, 8'h5A, 1'b1, 1'b1, 3'b000, 3'b000);
        rd(7'h20);
        drive(1'b0, 7'h20, 8'h77, 1'b0, 1'b1, 3'b000, 3'b000);
        rd(7'h20);
        // Indirect write through FSR.
        drive(1'b0, 7'h04, 8'h20, 1'b1, 1'b1, 3'b000, 3'b000);
        drive(1'b0, 7'h00, 8'hC3, 1'b1, 1'b1, 3'b000, 3'b000);
        rd(7'h20);
        rd(7'h00);
        // FSR pointing at INDF: reads zero, writes dropped.
        drive(1'b0, 7'h04, 8'h00, 1'b1, 1'b1, 3'b000, 3'b000);
        drive(1'b0, 7'h00, 8'hFF, 1'b1, 1'b1, 3'b000, 3'b000);
        rd(7'h03);
        rd(7'h04);
        // Flags, then direct STATUS write merged with a Z update.
        drive(1'b0, 7'h10, 8'h00, 1'b0, 1'b0, 3'b001, 3'b001);
        drive(1'b0, 7'h03, 8'hFF, 1'b1, 1'b1, 3'b100, 3'b000);
        rd(7'h03);
        // Back-to-back writes.
        drive(1'b0, 7'h30, 8'h11, 1'b1, 1'b1, 3'b000, 3'b000);
        drive(1'b0, 7'h30, 8'h22, 1'b1, 1'b1, 3'b000, 3'b000);
        rd(7'h30);
        // Reset with a pending write loses it.
        drive(1'b1, 7'h30, 8'h99, 1'b1, 1'b1, 3'b111, 3'b111);
        rd(7'h30);
        rd(7'h03);
        for (int n = 0; n < 3000; n++) begin
            r = int'($urandom_range(0, 9));
            case (r)
                0:       a = 7'h00;
                1:       a = 7'h03;
                2:       a = 7'h04;
                3:       a = 7'($urandom_range(0, 15));
                default: a = 7'($urandom);
            endcase
            x = (a == 7'h04 && $urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 15))
                                                          : 8'($urandom);
            drive(($urandom_range(0, 149) == 0), a, x,
                  1'($urandom), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'b000,
                  3'($urandom));
        end
        for (int k = 0; k < 20 && sb.size() > 0; k++) @(negedge clk);
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain left=%0d exp=0", sb.size());
        end
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
